// File: rtl/usb_txn_ctrl.sv
// usb_txn_ctrl
//    Transaction sequencer sitting between a host and a USB bit-level
//    transmitter/receiver pair.  A host packet of up to MAX_BYTES bytes is
//    latched on start and streamed to the transmitter one bit per cycle,
//    LSB of byte 0 first.  When a handshake is expected, the block then
//    waits for a SYNC+PID reply from the receiver and decodes it as
//    ACK/NAK/STALL.  NAK, timeout and malformed replies are retried up to
//    MAX_RETRY times with the same latched packet.
//
// Ports
//    clk, rst                  clock, synchronous active-high reset
//    start                     begin a transaction (ignored while busy)
//    pkt_data, pkt_len         packet bytes and byte count, latched on start
//    expect_hs                 1 = wait for a handshake after transmit
//    busy, done                transaction in progress / 1-cycle completion
//    result, retries_used      00 ACK, 01 NAK, 10 STALL, 11 ERROR; retries
//    data_bit/start/end        bit stream to the transmitter (combinational)
//    tx_ready, tx_sending      transmitter status
//    rx_bit, rx_sending, rx_eop receiver bit stream and end-of-packet
module usb_txn_ctrl #(
   parameter int MAX_BYTES = 8,
   parameter int TIMEOUT   = 64,
   parameter int MAX_RETRY = 3
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [8*MAX_BYTES-1:0]         pkt_data,
   input  logic [$clog2(MAX_BYTES+1)-1:0] pkt_len,
   input  logic                           expect_hs,
   output logic                           busy,
   output logic                           done,
   output logic [1:0]                     result,
   output logic [1:0]                     retries_used,
   output logic                           data_bit,
   output logic                           data_start,
   output logic                           data_end,
   input  logic                           tx_ready,
   input  logic                           tx_sending,
   input  logic                           rx_bit,
   input  logic                           rx_sending,
   input  logic                           rx_eop
);

   localparam int LW = $clog2(MAX_BYTES+1);
   localparam int IW = $clog2(8*MAX_BYTES);
   localparam int TW = $clog2(TIMEOUT);

   localparam logic [1:0] RES_OK    = 2'b00;
   localparam logic [1:0] RES_NAK   = 2'b01;
   localparam logic [1:0] RES_STALL = 2'b10;
   localparam logic [1:0] RES_ERR   = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_TX, S_SEND, S_DRAIN, S_WAIT_RX, S_RECV, S_CHECK, S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [8*MAX_BYTES-1:0] pkt_q, pkt_d;
   logic [LW-1:0]          len_q, len_d;
   logic                   hs_q, hs_d;
   logic [IW-1:0]          bit_idx_q, bit_idx_d;
   logic [TW-1:0]          tmo_q, tmo_d;
   logic [15:0]            rx_word_q, rx_word_d;
   logic [4:0]             rx_cnt_q, rx_cnt_d;
   logic [1:0]             result_q, result_d;
   logic [1:0]             retries_q, retries_d;
   logic                   busy_q, done_q;

   logic [IW-1:0]          last_idx;
   logic                   outcome_vld;
   logic [1:0]             outcome;
   logic                   hs_valid;

   // Index of the final packet bit; length is already range-checked here.
   assign last_idx = IW'(((IW+1)'(len_q) << 3) - (IW+1)'(1));

   // Handshake shape: exactly 16 bits, SYNC byte, PID check nibble.
   assign hs_valid = (rx_cnt_q == 5'd16) && (rx_word_q[7:0] == 8'h80) &&
                     (rx_word_q[15:12] == ~rx_word_q[11:8]);

   always_comb begin
      state_d     = state_q;
      pkt_d       = pkt_q;
      len_d       = len_q;
      hs_d        = hs_q;
      bit_idx_d   = bit_idx_q;
      tmo_d       = tmo_q;
      rx_word_d   = rx_word_q;
      rx_cnt_d    = rx_cnt_q;
      result_d    = result_q;
      retries_d   = retries_q;
      data_bit    = 1'b0;
      data_start  = 1'b0;
      data_end    = 1'b0;
      outcome_vld = 1'b0;
      outcome     = RES_OK;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               pkt_d     = pkt_data;
               len_d     = pkt_len;
               hs_d      = expect_hs;
               retries_d = 2'b00;
               result_d  = RES_OK;
               if (pkt_len == '0 || pkt_len > LW'(MAX_BYTES)) begin
                  result_d = RES_ERR;
                  state_d  = S_DONE;
               end else begin
                  state_d  = S_WAIT_TX;
               end
            end
         end
         S_WAIT_TX: begin
            // First bit goes out in the same cycle the transmitter is ready.
            if (tx_ready) begin
               data_start = 1'b1;
               data_bit   = pkt_q[0];
               bit_idx_d  = IW'(1);
               state_d    = S_SEND;
            end
         end
         S_SEND: begin
            data_bit = pkt_q[bit_idx_q];
            if (bit_idx_q == last_idx) begin
               data_end = 1'b1;
               state_d  = S_DRAIN;
            end else begin
               bit_idx_d = bit_idx_q + IW'(1);
            end
         end
         S_DRAIN: begin
            // Transmitter finishes EOP before the bus turns around.
            if (tx_ready && !tx_sending) begin
               if (!hs_q) begin
                  result_d = RES_OK;
                  state_d  = S_DONE;
               end else begin
                  tmo_d   = '0;
                  state_d = S_WAIT_RX;
               end
            end
         end
         S_WAIT_RX: begin
            tmo_d = tmo_q + TW'(1);
            if (rx_sending) begin
               rx_word_d    = '0;
               rx_word_d[0] = rx_bit;
               rx_cnt_d     = 5'd1;
               state_d      = S_RECV;
            end else if (tmo_q == TW'(TIMEOUT-1)) begin
               outcome_vld = 1'b1;
               outcome     = RES_ERR;
            end
         end
         S_RECV: begin
            if (rx_sending) begin
               if (rx_cnt_q < 5'd16) rx_word_d[rx_cnt_q[3:0]] = rx_bit;
               // 17 marks "too long" without wrapping back to a legal count.
               if (rx_cnt_q < 5'd17) rx_cnt_d = rx_cnt_q + 5'd1;
            end
            if (rx_eop) state_d = S_CHECK;
         end
         S_CHECK: begin
            outcome_vld = 1'b1;
            outcome     = RES_ERR;
            if (hs_valid) begin
               case (rx_word_q[15:8])
                  8'hD2:   outcome = RES_OK;
                  8'h5A:   outcome = RES_NAK;
                  8'h1E:   outcome = RES_STALL;
                  default: outcome = RES_ERR;
               endcase
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // NAK and errors are retried; ACK and STALL finish immediately.
      if (outcome_vld) begin
         if ((outcome == RES_NAK || outcome == RES_ERR) &&
             retries_q < 2'(MAX_RETRY)) begin
            retries_d = retries_q + 2'd1;
            state_d   = S_WAIT_TX;
         end else begin
            result_d  = outcome;
            state_d   = S_DONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pkt_q     <= '0;
         len_q     <= '0;
         hs_q      <= 1'b0;
         bit_idx_q <= '0;
         tmo_q     <= '0;
         rx_word_q <= '0;
         rx_cnt_q  <= '0;
         result_q  <= 2'b00;
         retries_q <= 2'b00;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pkt_q     <= pkt_d;
         len_q     <= len_d;
         hs_q      <= hs_d;
         bit_idx_q <= bit_idx_d;
         tmo_q     <= tmo_d;
         rx_word_q <= rx_word_d;
         rx_cnt_q  <= rx_cnt_d;
         result_q  <= result_d;
         retries_q <= retries_d;
         busy_q    <= (state_d != S_IDLE);
         done_q    <= (state_d == S_DONE);
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign result       = result_q;
   assign retries_used = retries_q;

endmodule
